conv_window_3x3: RTL and testbench

- Raster-stream to 3x3 window generator. It is the producing end of the 9-pixel input side of the 3x3 multiply-accumulate stage.
- Accepts one signed 8-bit pixel per valid cycle. Buffers two image lines and presents each complete 3x3 neighbourhood as nine parallel pixels with a valid strobe.
- Output is "valid" convolution only, with no padding: (IMG_W-2)*(IMG_H-2) windows per frame.

---
 rtl/conv_window_3x3_if.sv | 35 +++
 rtl/conv_window_3x3.sv | 130 +++++++++++++
 tb/tb_conv_window_3x3.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/conv_window_3x3_if.sv
// Pixel-stream in / 3x3 window out bundle for conv_window_3x3.
// Handshake: pix_valid qualifies pix_sof and pix_in, and the pixel is taken
// on every rising edge where pix_valid=1. There is no ready signal and no
// backpressure. win_valid qualifies win_1..win_9 and frame_done for exactly
// one cycle per window, and the consumer must take every win_valid beat.
interface conv_window_3x3_if;
  logic              pix_valid;
  logic              pix_sof;
  logic signed [7:0] pix_in;
  logic signed [7:0] win_1;
  logic signed [7:0] win_2;
  logic signed [7:0] win_3;
  logic signed [7:0] win_4;
  logic signed [7:0] win_5;
  logic signed [7:0] win_6;
  logic signed [7:0] win_7;
  logic signed [7:0] win_8;
  logic signed [7:0] win_9;
  logic              win_valid;
  logic              frame_done;

  // Pixel producer / window consumer side
  modport master (
    output pix_valid, pix_sof, pix_in,
    input  win_1, win_2, win_3, win_4, win_5, win_6, win_7, win_8, win_9,
    input  win_valid, frame_done
  );

  // Window generator side
  modport slave (
    input  pix_valid, pix_sof, pix_in,
    output win_1, win_2, win_3, win_4, win_5, win_6, win_7, win_8, win_9,
    output win_valid, frame_done
  );
endinterface

// File: rtl/conv_window_3x3.sv
// Raster-stream to 3x3 window generator. Two line delays plus a 3x3 shift
// window. Emits one window per pixel at row>=2, col>=2 ("valid" convolution,
// no padding). Output registers load only on emitted windows, so the window
// outputs hold their last value between win_valid pulses.
module conv_window_3x3 #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input logic             sys_clk,
  input logic             rst_n,
  conv_window_3x3_if.slave bus
);
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;
  logic [CW-1:0]     w_col;
  logic [RW-1:0]     w_row;
  logic [CW-1:0]     w_col_nxt;
  logic [RW-1:0]     w_row_nxt;
  logic              w_sof;
  logic              w_emit;
  logic              w_last;

  logic signed [7:0] r_lb0 [IMG_W];
  logic signed [7:0] r_lb1 [IMG_W];
  logic signed [7:0] w_lb0_rd;
  logic signed [7:0] w_lb1_rd;

  logic signed [7:0] r_win [9];
  logic signed [7:0] w_win_nxt [9];
  logic signed [7:0] r_out [9];
  logic              r_valid;
  logic              r_done;

  // Effective pixel position: a qualified start-of-frame forces (0,0)
  always_comb begin
    w_sof = bus.pix_valid & bus.pix_sof;
    w_col = w_sof ? '0 : r_col;
    w_row = w_sof ? '0 : r_row;
  end

  // Raster advance from the effective position, wrapping at end of frame
  always_comb begin
    w_col_nxt = w_col + CW'(1);
    w_row_nxt = w_row;
    if (w_col == COL_LAST) begin
      w_col_nxt = '0;
      w_row_nxt = (w_row == ROW_LAST) ? '0 : w_row + RW'(1);
    end
  end

  // Window emit and last-window decode for the pixel being accepted
  always_comb begin
    w_emit = bus.pix_valid && (w_row >= ROW_TWO) && (w_col >= COL_TWO);
    w_last = (w_col == COL_LAST) && (w_row == ROW_LAST);
  end

  // Line-buffer read and next window: shift left, new column on the right
  always_comb begin
    w_lb0_rd     = r_lb0[w_col];
    w_lb1_rd     = r_lb1[w_col];
    w_win_nxt[0] = r_win[1];
    w_win_nxt[1] = r_win[2];
    w_win_nxt[2] = w_lb1_rd;
    w_win_nxt[3] = r_win[4];
    w_win_nxt[4] = r_win[5];
    w_win_nxt[5] = w_lb0_rd;
    w_win_nxt[6] = r_win[7];
    w_win_nxt[7] = r_win[8];
    w_win_nxt[8] = bus.pix_in;
  end

  // Column/row counters advance only on accepted pixels
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (bus.pix_valid) begin
      r_col <= w_col_nxt;
      r_row <= w_row_nxt;
    end
  end

  // Line delays: LB1 takes the old LB0 entry, LB0 takes the new pixel
  always_ff @(posedge sys_clk) begin
    if (bus.pix_valid) begin
      r_lb1[w_col] <= r_lb0[w_col];
      r_lb0[w_col] <= bus.pix_in;
    end
  end

  // Window shift plus output capture on emitted windows
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) begin
        r_win[i] <= '0;
        r_out[i] <= '0;
      end
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_valid <= w_emit;
      r_done  <= w_emit & w_last;
      if (bus.pix_valid) begin
        for (int i = 0; i < 9; i++) r_win[i] <= w_win_nxt[i];
      end
      if (w_emit) begin
        for (int i = 0; i < 9; i++) r_out[i] <= w_win_nxt[i];
      end
    end
  end

  assign bus.win_1      = r_out[0];
  assign bus.win_2      = r_out[1];
  assign bus.win_3      = r_out[2];
  assign bus.win_4      = r_out[3];
  assign bus.win_5      = r_out[4];
  assign bus.win_6      = r_out[5];
  assign bus.win_7      = r_out[6];
  assign bus.win_8      = r_out[7];
  assign bus.win_9      = r_out[8];
  assign bus.win_valid  = r_valid;
  assign bus.frame_done = r_done;
endmodule

// File: tb/tb_conv_window_3x3.sv
// Bench for conv_window_3x3: a 4x4 instance and a 3x3 instance, driven one
// at a time. A reference model stores each frame as a 2-D image indexed by
// (row, col) and forms expected windows directly from image neighbourhoods.
module tb_conv_window_3x3;
  logic sys_clk;
  logic rst_n;

  conv_window_3x3_if if0 ();
  conv_window_3x3_if if1 ();

  conv_window_3x3 #(.IMG_W(4), .IMG_H(4)) u_dut0 (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .bus     (if0.slave)
  );

  conv_window_3x3 #(.IMG_W(3), .IMG_H(3)) u_dut1 (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .bus     (if1.slave)
  );

  // ---------------- clock / reset ----------------
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [72:0] exp_q [$];           // {frame_done, win_1..win_9}
  logic [72:0] win_log [$];         // observed windows of current test
  int          n_win;
  int          n_done;

  // reference model
  logic [7:0] img [4][4];
  int         m_row, m_col, m_w, m_h;
  logic [71:0] m_last;
  int         sel;                  // 0: 4x4 DUT, 1: 3x3 DUT

  task automatic check(input string tag, input logic [72:0] obs, input logic [72:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [72:0] pack0();
    return {if0.frame_done, if0.win_1, if0.win_2, if0.win_3, if0.win_4, if0.win_5,
            if0.win_6, if0.win_7, if0.win_8, if0.win_9};
  endfunction

  function automatic logic [72:0] pack1();
    return {if1.frame_done, if1.win_1, if1.win_2, if1.win_3, if1.win_4, if1.win_5,
            if1.win_6, if1.win_7, if1.win_8, if1.win_9};
  endfunction

  task automatic model_reset(input int w, input int h);
    m_row = 0; m_col = 0; m_w = w; m_h = h; m_last = '0;
    exp_q.delete();
  endtask

  // Place pixel in the image; if a full 3x3 neighbourhood ends here, push it
  task automatic model_accept(input bit s, input logic [7:0] p, output bit ev);
    logic [71:0] wv;
    if (s) begin m_row = 0; m_col = 0; end
    img[m_row][m_col] = p;
    ev = (m_row >= 2) && (m_col >= 2);
    if (ev) begin
      wv = '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          wv = {wv[63:0], img[m_row - 2 + r][m_col - 2 + c]};
      exp_q.push_back({(m_row == m_h - 1) && (m_col == m_w - 1), wv});
    end
    m_col++;
    if (m_col == m_w) begin
      m_col = 0;
      m_row++;
      if (m_row == m_h) m_row = 0;
    end
  endtask

  // ---------------- driver: one cycle, then check ----------------
  task automatic step(input bit v, input bit s, input logic [7:0] p);
    bit          ev;
    logic [72:0] exp, obs;
    logic        ov, idle_v;
    @(negedge sys_clk);
    if (sel == 0) begin
      if0.pix_valid = v; if0.pix_sof = s; if0.pix_in = p;
      if1.pix_valid = 1'b0; if1.pix_sof = 1'b0; if1.pix_in = 8'($urandom);
    end else begin
      if1.pix_valid = v; if1.pix_sof = s; if1.pix_in = p;
      if0.pix_valid = 1'b0; if0.pix_sof = 1'b0; if0.pix_in = 8'($urandom);
    end
    @(posedge sys_clk);
    #1;
    ev = 1'b0;
    if (v) model_accept(s, p, ev);
    obs    = (sel == 0) ? pack0() : pack1();
    ov     = (sel == 0) ? if0.win_valid : if1.win_valid;
    idle_v = (sel == 0) ? if1.win_valid : if0.win_valid;
    check("win_valid", {72'd0, ov}, {72'd0, ev});
    check("idle_win_valid", {72'd0, idle_v}, 73'd0);
    if (ev) begin
      exp = exp_q.pop_front();
      m_last = exp[71:0];
      check("window", obs, exp);
    end else begin
      check("hold", obs, {1'b0, m_last});
    end
    if (ov === 1'b1) begin
      n_win++;
      win_log.push_back(obs);
    end
    if (obs[72] === 1'b1) n_done++;
  endtask

  task automatic start_test();
    n_win = 0; n_done = 0;
    win_log.delete();
  endtask

  task automatic end_test(input string tag, input int exp_win, input int exp_done);
    check({tag, "_windows"}, 73'(n_win), 73'(exp_win));
    check({tag, "_frame_done"}, 73'(n_done), 73'(exp_done));
  endtask

  // idle cycles between pixels; sof is randomised while pix_valid=0
  task automatic gap(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'($urandom), 8'($urandom));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0;
    if0.pix_valid = 1'b0; if0.pix_sof = 1'b0; if0.pix_in = '0;
    if1.pix_valid = 1'b0; if1.pix_sof = 1'b0; if1.pix_in = '0;
    sel = 0;
    model_reset(4, 4);
    repeat (3) @(posedge sys_clk);
    #1;
    check("reset_out0", {if0.win_valid, pack0()} , 74'd0);
    check("reset_out1", {if1.win_valid, pack1()} , 74'd0);
    @(negedge sys_clk);
    rst_n = 1'b1;

    // signed extremes on 3x3: centre 127, rest -128
    sel = 1;
    model_reset(3, 3);
    start_test();
    for (int i = 0; i < 9; i++) step(1'b1, i == 0, (i == 4) ? 8'h7F : 8'h80);
    end_test("signed3x3", 1, 1);
    check("signed3x3_win", (win_log.size() > 0) ? win_log[0] : 73'd0,
          {1'b1, {4{8'h80}}, 8'h7F, {4{8'h80}}});

    // contiguous 4x4 frame 0..15
    sel = 0;
    model_reset(4, 4);
    start_test();
    for (int i = 0; i < 16; i++) step(1'b1, i == 0, 8'(i));
    end_test("contig", 4, 1);
    check("contig_first", (win_log.size() > 0) ? win_log[0] : 73'd0,
          {1'b0, 72'h00_01_02_04_05_06_08_09_0A});
    check("contig_last", (win_log.size() > 3) ? win_log[3] : 73'd0,
          {1'b1, 72'h05_06_07_09_0A_0B_0D_0E_0F});

    // same stream with irregular gaps
    start_test();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, i == 0, 8'(i));
      gap($urandom_range(0, 2));
    end
    end_test("gaps", 4, 1);
    check("gaps_first", (win_log.size() > 0) ? win_log[0] : 73'd0,
          {1'b0, 72'h00_01_02_04_05_06_08_09_0A});

    // back-to-back frames, sof only on the very first pixel
    start_test();
    for (int i = 0; i < 32; i++) step(1'b1, i == 0, 8'(i));
    end_test("b2b", 8, 2);
    check("b2b_f2_first", (win_log.size() > 4) ? win_log[4] : 73'd0,
          {1'b0, 72'h10_11_12_14_15_16_18_19_1A});

    // sof on pixel 6 aborts the frame; new frame 100..115
    start_test();
    for (int i = 0; i < 6; i++) step(1'b1, i == 0, 8'(i));
    for (int i = 0; i < 16; i++) step(1'b1, i == 0, 8'(100 + i));
    end_test("abort", 4, 1);
    check("abort_first", (win_log.size() > 0) ? win_log[0] : 73'd0,
          {1'b0, 72'h64_65_66_68_69_6A_6C_6D_6E});

    // random pixels with random gaps, two frames
    start_test();
    for (int i = 0; i < 32; i++) begin
      step(1'b1, i == 0, 8'($urandom));
      if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 3));
    end
    end_test("random", 8, 2);

    // async reset mid-frame after pixel 9
    start_test();
    for (int i = 0; i < 10; i++) step(1'b1, i == 0, 8'(200 + i));
    @(negedge sys_clk);
    if0.pix_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out0", {if0.win_valid, pack0()}, 74'd0);
    @(negedge sys_clk);
    rst_n = 1'b1;
    model_reset(4, 4);
    start_test();
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'($urandom));
    end_test("midrst", 4, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // global time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
